// File: rtl/ps2_pkg.sv
// Shared constants, FSM encoding and event layout for the PS/2 scancode controller.
package ps2_pkg;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    localparam int unsigned EV_BRK     = 8;
    localparam int unsigned EV_EXT     = 9;
    localparam int unsigned EV_SEQ_LSB = 10;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } ps2_state_e;

    function automatic logic [15:0] pack_event(input logic [5:0] seq, input logic ext,
                                               input logic brk, input logic [7:0] code);
        logic [15:0] ev;
        ev                         = '0;
        ev[7:0]                    = code;
        ev[EV_BRK]                 = brk;
        ev[EV_EXT]                 = ext;
        ev[EV_SEQ_LSB +: 6]        = seq;
        return ev;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with flush and occupancy count.
// Pointers carry one extra bit so full and empty are distinguishable.
module sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             pop_eff, push_eff;

    assign count_o  = wptr_q - rptr_q;
    assign empty_o  = (wptr_q == rptr_q);
    assign full_o   = (count_o == (AW + 1)'(DEPTH));
    assign pop_eff  = pop_i & ~empty_o;
    // A pop on the same edge frees the slot the push needs.
    assign push_eff = push_i & (~full_o | pop_eff);

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_eff) wptr_q <= wptr_q + 1'b1;
            if (pop_eff)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i && push_eff) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

    assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/ps2_scancode_ctrl.sv
// Decodes PS/2 scancode bytes (E0/F0 prefixes) into 16-bit key events buffered in a FIFO.
// Full-FIFO drops are counted (saturating) and flagged sticky.
module ps2_scancode_ctrl
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          axis_aclk_i,
    input  logic                          axis_areset_i,
    input  logic                          enable_i,
    input  logic                          flush_i,
    input  logic                          s_axis_tvalid_i,
    output logic                          s_axis_tready_o,
    input  logic [7:0]                    s_axis_tdata_i,
    output logic                          m_axis_tvalid_o,
    input  logic                          m_axis_tready_i,
    output logic [15:0]                   m_axis_tdata_o,
    output logic [$clog2(FIFO_DEPTH):0]   pending_o,
    output logic                          overflow_o,
    output logic [7:0]                    drop_count_o
);

    ps2_state_e  state_q, state_d;
    logic        ready_q;
    logic [5:0]  seq_q;
    logic        overflow_q;
    logic [7:0]  drop_cnt_q;

    logic        byte_hs, emit, ev_ext, ev_brk;
    logic        fifo_full, fifo_empty, pop, can_push, push, drop;
    logic [15:0] ev_word;

    assign byte_hs = s_axis_tvalid_i & ready_q;

    always_ff @(posedge axis_aclk_i) begin
        if (axis_areset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_i || !enable_i) begin
            state_d = S_IDLE;
        end else if (byte_hs) begin
            if (s_axis_tdata_i == SC_EXT) begin
                state_d = S_EXT;
            end else if (s_axis_tdata_i == SC_BRK) begin
                state_d = (state_q == S_EXT || state_q == S_EXT_BRK) ? S_EXT_BRK : S_BRK;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    always_comb begin
        emit   = byte_hs & enable_i & ~flush_i &
                 (s_axis_tdata_i != SC_EXT) & (s_axis_tdata_i != SC_BRK);
        ev_ext = (state_q == S_EXT) || (state_q == S_EXT_BRK);
        ev_brk = (state_q == S_BRK) || (state_q == S_EXT_BRK);
    end

    assign ev_word  = pack_event(seq_q, ev_ext, ev_brk, s_axis_tdata_i);
    assign pop      = m_axis_tready_i & ~fifo_empty;
    assign can_push = ~fifo_full | pop;
    assign push     = emit & can_push;
    assign drop     = emit & ~can_push;

    always_ff @(posedge axis_aclk_i) begin
        if (axis_areset_i) begin
            ready_q    <= 1'b0;
            seq_q      <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            ready_q <= 1'b1;
            if (push) seq_q <= seq_q + 1'b1;
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (axis_aclk_i),
        .rst_i   (axis_areset_i),
        .flush_i (flush_i),
        .push_i  (push),
        .wdata_i (ev_word),
        .pop_i   (m_axis_tready_i),
        .rdata_o (m_axis_tdata_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (pending_o)
    );

    assign s_axis_tready_o = ready_q;
    assign m_axis_tvalid_o = ~fifo_empty;
    assign overflow_o      = overflow_q;
    assign drop_count_o    = drop_cnt_q;

endmodule

// File: doc/ps2_scancode_ctrl.md
# ps2_scancode_ctrl

Protocol controller placed downstream of the PS/2 keyboard AXI-stream source. It consumes raw scancode bytes, resolves the 0xE0 (extended) and 0xF0 (break) prefixes with a state machine, and emits one 16-bit key-event word per key action. Events are buffered in a small FIFO, so a slow CPU-side consumer never stalls the single-slot keyboard source. Drops caused by a full FIFO are counted and flagged.

## Interface
- FIFO_DEPTH, 8, event FIFO entries; must be a power of 2, minimum 2.
- axis_aclk_i  in  1  system clock; all logic on the rising edge.
- axis_areset_i  in  1  reset; synchronous, active-high.
- enable_i  in  1  0: input bytes accepted and discarded, FSM held in S_IDLE.
- flush_i  in  1  1 for one cycle: empty FIFO, FSM to S_IDLE; counters untouched.
- s_axis_tvalid_i  in  1  scancode byte valid.
- s_axis_tready_o  out  1  accept; 0 in reset, then constant 1.
- s_axis_tdata_i  in  8  raw scancode.
- m_axis_tvalid_o  out  1  FIFO not empty.
- m_axis_tready_i  in  1  consumer accept.
- m_axis_tdata_o  out  16  event: [15:10] seq, [9] ext, [8] brk, [7:0] code.
- pending_o  out  log2(FIFO_DEPTH)+1  FIFO occupancy.
- overflow_o  out  1  sticky; set on first drop, cleared only by reset.
- drop_count_o  out  8  dropped events, saturates at 255.

## Operation
- Byte handshake: s_axis_tvalid_i & s_axis_tready_o on a rising edge.
- FSM states: S_IDLE, S_EXT, S_BRK, S_EXT_BRK. In every state:
  - 0xE0 -> S_EXT.
  - 0xF0 -> S_BRK from S_IDLE/S_BRK, or S_EXT_BRK from S_EXT/S_EXT_BRK.
  - Any other byte emits an event and returns to S_IDLE: ext=1 in S_EXT/S_EXT_BRK, brk=1 in S_BRK/S_EXT_BRK.
- Prefix bytes never produce events. Non-prefix codes, including 0xAA, 0xFA and 0xE1, are passed through as plain codes.
- Event emission:
  - FIFO not full, or a pop occurs on the same edge: push {seq, ext, brk, code} and increment seq (mod 64).
  - Otherwise drop: seq is not incremented, overflow_o <= 1, drop_count_o increments unless already 255. The FSM still returns to S_IDLE.
- enable_i=0: handshake still completes, byte ignored, FSM forced to S_IDLE. FIFO drain continues.
- flush_i has priority over push and pop on the same edge. Bytes accepted on that edge are discarded.
- Output: first-word-fall-through. m_axis_tdata_o is the FIFO head, valid while m_axis_tvalid_o=1, and held stable until the handshake.
- Reset: FSM S_IDLE, FIFO empty, seq=0, and every output 0, including m_axis_tdata_o, pending_o, overflow_o, drop_count_o, s_axis_tready_o.

## Timing
- Latency: a final byte accepted on edge k gives m_axis_tvalid_o=1 from edge k onward (visible in cycle k+1). No same-cycle bypass.
- pending_o updates on the same edge as the push/pop.
- Simultaneous push and pop:
  - When full: both succeed and occupancy is unchanged.
  - When empty: the push lands and the pop is ignored (tvalid was 0).
- Pop with tvalid=0 is a no-op. Read/write pointers wrap modulo FIFO_DEPTH, with an extra bit to tell full from empty.
- Reset mid-sequence (e.g. after 0xE0): the prefix is lost and the next byte is decoded from S_IDLE.

## Structure
- Package ps2_pkg holds:
  - constants SC_EXT=8'hE0, SC_BRK=8'hF0;
  - the state encoding;
  - event bit positions EV_EXT=9, EV_BRK=8, EV_SEQ_LSB=10.
- Sub-module sync_fifo (parameters WIDTH, DEPTH; synchronous active-high reset; flush input; count output). The decode FSM, seq counter and drop counter stay in the top.

## Test plan
- Bytes 0x1C; 0xF0,0x1C; 0xE0,0x75; 0xE0,0xF0,0x75, with consumer always ready -> events 0x001C, 0x051C, 0x0A75, 0x0F75 (seq 0..3), each appearing one cycle after its final byte.
- Consumer stalled, 10 plain codes 0x01..0x0A, FIFO_DEPTH=8 -> pending_o=8; codes 0x09 and 0x0A dropped; overflow_o=1; drop_count_o=2; the 8 drained events have seq 0..7.
- FIFO full, push and pop on the same edge -> no drop, pending_o stays 8, the new event is at the tail.
- Send 0xE0, assert axis_areset_i for 1 cycle, then send 0x75 -> event 0x0075 with seq 0; all outputs were 0 during reset.
- enable_i=0 while sending 0xF0,0x1C, then enable_i=1 and send 0x1C -> single event 0x001C; no break bit.
- 300 drops with the consumer stalled -> drop_count_o saturates at 255. Then flush_i: pending_o=0, tvalid=0, overflow_o stays 1.
